ps2_host_tx_ctrl: RTL



---
 rtl/ps2_host_tx_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device transmit controller with an APB register interface.
// Drives open-drain pull-down enables for ps2_clk/ps2_data and checks the device acknowledge.
module ps2_host_tx_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  // state   | meaning
  // IDLE    | lines released, waiting for a TXDATA write
  // INHIBIT | ps2_clk held low for INHIBIT_CYCLES
  // RTS     | clock released, start bit driven, counters cleared
  // SHIFT   | data/parity/stop placed on each device clock falling edge
  // ACK     | device acknowledge sampled on the next falling edge
  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK} state_t;

  localparam logic [CNT_W-1:0] LP_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_bit_cnt, w_bit_nxt;
  logic             r_clk_oe, w_clk_oe_nxt;
  logic             r_data_oe, w_data_oe_nxt;
  logic [7:0]       r_data;
  logic             r_parity;
  logic             r_done, r_err;
  logic             r_clk_s1, r_clk_s2, r_clk_s3;
  logic             r_dat_s1, r_dat_s2;

  logic w_fe, w_busy, w_access, w_wr, w_sel_tx, w_sel_st;
  logic w_wr_tx, w_clr_done, w_clr_err;
  logic w_load, w_set_done, w_set_err;
  logic w_unused;

  assign w_unused = ^{in_pprot, in_pstrb, in_paddr[31:4], in_paddr[1:0], in_pwdata[31:8]};

  assign w_fe       = r_clk_s3 & ~r_clk_s2;
  assign w_busy     = (r_state != S_IDLE);
  assign w_access   = in_psel & in_penable;
  assign w_wr       = w_access & in_pwrite;
  assign w_sel_tx   = (in_paddr[3:2] == 2'd0);
  assign w_sel_st   = (in_paddr[3:2] == 2'd1);
  assign w_wr_tx    = w_wr & w_sel_tx & ~w_busy;
  assign w_clr_done = w_wr & w_sel_st & in_pwdata[1];
  assign w_clr_err  = w_wr & w_sel_st & in_pwdata[2];

  assign in_pready   = w_access;
  assign in_pslverr  = w_wr & w_sel_tx & w_busy;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

  always_comb begin
    in_prdata = '0;
    if (in_psel) begin
      case (in_paddr[3:2])
        2'd0:    in_prdata = {24'h0, r_data};
        2'd1:    in_prdata = {29'h0, r_err, r_done, w_busy};
        default: in_prdata = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_load        = 1'b0;
    w_set_done    = 1'b0;
    w_set_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (w_wr_tx) begin
          w_load       = 1'b1;
          w_state_nxt  = S_INHIBIT;
          w_cnt_nxt    = '0;
          w_clk_oe_nxt = 1'b1;
        end
      end
      S_INHIBIT: begin
        if (r_cnt == LP_INH_LAST) begin
          w_state_nxt   = S_RTS;
          w_cnt_nxt     = '0;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RTS: begin
        w_bit_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT, S_ACK: begin
        if (w_fe) begin
          w_cnt_nxt = '0;
          if (r_state == S_SHIFT) begin
            // r_bit_cnt holds n-1 for the n-th falling edge
            w_bit_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt < 4'd8) begin
              w_data_oe_nxt = ~r_data[r_bit_cnt[2:0]];
            end else if (r_bit_cnt == 4'd8) begin
              w_data_oe_nxt = ~r_parity;
            end else begin
              w_data_oe_nxt = 1'b0;
              w_state_nxt   = S_ACK;
            end
          end else begin
            w_set_done    = ~r_dat_s2;
            w_set_err     = r_dat_s2;
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end else if (r_cnt == LP_TO_LAST) begin
          w_set_err     = 1'b1;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
      end
    endcase
  end

  // Hardware set of done/err takes priority over any clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_data   <= '0;
      r_parity <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (w_load) begin
        r_data   <= in_pwdata[7:0];
        r_parity <= ~^in_pwdata[7:0];
      end
      r_done <= w_set_done | (r_done & ~w_clr_done & ~w_load);
      r_err  <= w_set_err  | (r_err  & ~w_clr_err  & ~w_load);
    end
  end

endmodule
